// File: rtl/vga_sprite_compositor_if.sv
// Display-side bundle of the sprite compositor: controller switches in, VGA pins and frame pulse out.
interface vga_sprite_compositor_if #(
  parameter int unsigned N_SPRITES = 2
);
  logic [2*N_SPRITES-1:0] switch;
  logic                   hsync;
  logic                   vsync;
  logic                   video_on;
  logic [2:0]             rgb;
  logic [9:0]             pixelX;
  logic [9:0]             pixelY;
  logic                   frame_tick;

  modport master (
    input  switch,
    output hsync, vsync, video_on, rgb, pixelX, pixelY, frame_tick
  );

  modport slave (
    output switch,
    input  hsync, vsync, video_on, rgb, pixelX, pixelY, frame_tick
  );
endinterface

// File: rtl/vga_sprite_compositor.sv
// VGA timing generator compositing N square sprites over a solid background.
// Sprite positions advance once per frame at the start of vertical blanking.
module vga_sprite_compositor #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned N_SPRITES   = 2,
  parameter int unsigned SPRITE_SIZE = 16,
  parameter int unsigned STEP        = 2,
  parameter bit          WRAP        = 1'b0,
  parameter logic [2:0]  BG_COLOR    = 3'b110,
  parameter logic [3*N_SPRITES-1:0] SPRITE_COLORS = {3'b010, 3'b001}
) (
  input logic clk,
  input logic reset,
  vga_sprite_compositor_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned PW      = 11;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned MAX_X   = H_ACTIVE - SPRITE_SIZE;
  localparam int unsigned MAX_Y   = V_ACTIVE - SPRITE_SIZE;

  logic [DIV_W-1:0] div_cnt;
  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;
  logic [PW-1:0]    pos_x [N_SPRITES];
  logic [PW-1:0]    pos_y [N_SPRITES];
  logic             neg_x [N_SPRITES];
  logic             neg_y [N_SPRITES];

  logic             pix_en_c;
  logic             update_c;
  logic             active_c;
  logic             hsync_c;
  logic             vsync_c;
  logic [2:0]       color_c;
  logic [PW-1:0]    h_ext;
  logic [PW-1:0]    v_ext;

  // One axis move; returns {direction_is_minus, new_position}.
  function automatic logic [PW:0] step_axis(input logic [PW-1:0] pos,
                                            input logic          neg,
                                            input logic [PW-1:0] lim);
    logic [PW-1:0] fwd;
    fwd = pos + PW'(STEP);
    if (WRAP) begin
      if (fwd > lim) return {1'b0, fwd - (lim + PW'(1))};
      return {1'b0, fwd};
    end
    if (!neg) begin
      if (fwd > lim) return {1'b1, lim};
      return {1'b0, fwd};
    end
    if (pos < PW'(STEP)) return {1'b0, PW'(0)};
    return {1'b1, pos - PW'(STEP)};
  endfunction

  assign pix_en_c = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign update_c = pix_en_c && (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));
  assign active_c = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign hsync_c  = !((h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync_c  = !((v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
  assign h_ext    = PW'(h_cnt);
  assign v_ext    = PW'(v_cnt);

  // Scan from the highest index down so the lowest-index hit wins.
  always_comb begin
    color_c = BG_COLOR;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if ((h_ext >= pos_x[i]) && (h_ext < pos_x[i] + PW'(SPRITE_SIZE)) &&
          (v_ext >= pos_y[i]) && (v_ext < pos_y[i] + PW'(SPRITE_SIZE)))
        color_c = SPRITE_COLORS[3*i +: 3];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt        <= '0;
      h_cnt          <= '0;
      v_cnt          <= '0;
      bus.hsync      <= 1'b1;
      bus.vsync      <= 1'b1;
      bus.video_on   <= 1'b0;
      bus.rgb        <= 3'b000;
      bus.pixelX     <= '0;
      bus.pixelY     <= '0;
      bus.frame_tick <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        pos_x[i] <= PW'(2 * i * SPRITE_SIZE);
        pos_y[i] <= '0;
        neg_x[i] <= 1'b0;
        neg_y[i] <= 1'b0;
      end
    end else begin
      bus.frame_tick <= update_c;
      div_cnt        <= pix_en_c ? '0 : div_cnt + DIV_W'(1);
      if (pix_en_c) begin
        bus.hsync    <= hsync_c;
        bus.vsync    <= vsync_c;
        bus.video_on <= active_c;
        bus.rgb      <= active_c ? color_c : 3'b000;
        bus.pixelX   <= 10'(h_cnt);
        bus.pixelY   <= 10'(v_cnt);
        if (h_cnt == HW'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
        end else begin
          h_cnt <= h_cnt + HW'(1);
        end
      end
      // Switches are only looked at here, during the first blanking line.
      if (update_c) begin
        for (int i = 0; i < N_SPRITES; i++) begin
          if (bus.switch[2*i])
            {neg_x[i], pos_x[i]} <= step_axis(pos_x[i], neg_x[i], PW'(MAX_X));
          if (bus.switch[2*i+1])
            {neg_y[i], pos_y[i]} <= step_axis(pos_y[i], neg_y[i], PW'(MAX_Y));
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Scoreboard bench: a bounce instance (CLK_DIV=2) and a wrap instance (CLK_DIV=1) on a small raster.
module tb_vga_sprite_compositor;

  localparam int HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int VA = 12, VF = 1, VS = 2, VB = 1;
  localparam int H_TOT = HA + HF + HS + HB;
  localparam int V_TOT = VA + VF + VS + VB;
  localparam int SZ = 4;
  localparam int NF = 17;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [2:0] rgb;
    logic [9:0] px;
    logic [9:0] py;
    logic       ftick;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  vga_sprite_compositor_if #(.N_SPRITES(2)) vif_a ();
  vga_sprite_compositor_if #(.N_SPRITES(2)) vif_b ();

  vga_sprite_compositor #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .N_SPRITES(2), .SPRITE_SIZE(SZ), .STEP(2), .WRAP(1'b0),
    .BG_COLOR(3'b110), .SPRITE_COLORS({3'b010, 3'b001})
  ) dut_a (.clk(clk), .reset(rst_a), .bus(vif_a));

  vga_sprite_compositor #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .N_SPRITES(2), .SPRITE_SIZE(SZ), .STEP(2), .WRAP(1'b1),
    .BG_COLOR(3'b110), .SPRITE_COLORS({3'b010, 3'b001})
  ) dut_b (.clk(clk), .reset(rst_b), .bus(vif_b));

  // Hand-derived positions per frame (MAX_X=12, MAX_Y=8, STEP=2).
  int bx [NF] = '{0, 2, 4, 6, 8, 10, 12, 12, 10, 8, 6, 4, 2, 0, 0, 2, 4};
  int by [NF] = '{0, 2, 4, 6, 8, 8, 6, 4, 2, 0, 0, 2, 4, 6, 8, 8, 6};
  int wx [NF] = '{0, 2, 4, 6, 8, 10, 12, 1, 3, 5, 7, 9, 11, 0, 2, 4, 6};

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t last_a, last_b;
  int   m_h [2] = '{0, 0};
  int   m_v [2] = '{0, 0};
  int   m_div [2] = '{0, 0};
  int   m_f [2] = '{NF, NF};
  int   ovl [2] = '{0, 0};
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic bit hit(input int h, input int v, input int x, input int y);
    return (h >= x) && (h < x + SZ) && (v >= y) && (v < y + SZ);
  endfunction

  function automatic void positions(input int d, input int f,
                                    output int x0, output int y0, output int x1, output int y1);
    x0 = (d == 0) ? bx[f] : wx[f];
    y0 = 0;
    x1 = 8;
    y1 = (d == 0) ? by[f] : 0;
  endfunction

  function automatic exp_t exp_pixel(input int h, input int v, input int x0, input int y0,
                                     input int x1, input int y1);
    exp_t e;
    e.hsync    = !((h >= HA + HF) && (h < HA + HF + HS));
    e.vsync    = !((v >= VA + VF) && (v < VA + VF + VS));
    e.video_on = (h < HA) && (v < VA);
    if (!e.video_on)          e.rgb = 3'b000;
    else if (hit(h, v, x0, y0)) e.rgb = 3'b001;
    else if (hit(h, v, x1, y1)) e.rgb = 3'b010;
    else                      e.rgb = 3'b110;
    e.px    = 10'(h);
    e.py    = 10'(v);
    e.ftick = (h == 0) && (v == VA);
    return e;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e = '0;
    e.hsync = 1'b1;
    e.vsync = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t e);
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h (x=%0d y=%0d)", name, $time, act, e, e.px, e.py);
    end
  endtask

  task automatic check_bit(input string name, input bit act, input bit e);
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s got=%0b expected=%0b", name, act, e);
    end
  endtask

  // Stimulus side: predict what each DUT registers on this edge and queue it.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic rst_d;
      int   div_d, x0, y0, x1, y1;
      exp_t e;
      rst_d = (d == 0) ? rst_a : rst_b;
      div_d = (d == 0) ? 2 : 1;
      if (rst_d) begin
        m_h[d] = 0; m_v[d] = 0; m_div[d] = 0; m_f[d] = 0;
        if (d == 0) q_a.push_back(rst_exp()); else q_b.push_back(rst_exp());
      end else if (m_f[d] < NF) begin
        if (m_div[d] == div_d - 1) begin
          m_div[d] = 0;
          positions(d, m_f[d], x0, y0, x1, y1);
          e = exp_pixel(m_h[d], m_v[d], x0, y0, x1, y1);
          if (e.video_on && hit(m_h[d], m_v[d], x0, y0) && hit(m_h[d], m_v[d], x1, y1)) ovl[d]++;
          if (d == 0) q_a.push_back(e); else q_b.push_back(e);
          if (m_h[d] == 0 && m_v[d] == VA) m_f[d]++;
          if (m_h[d] == H_TOT - 1) begin
            m_h[d] = 0;
            m_v[d] = (m_v[d] == V_TOT - 1) ? 0 : m_v[d] + 1;
          end else begin
            m_h[d]++;
          end
        end else begin
          m_div[d]++;
        end
      end
    end
  end

  // Monitor: compare presented outputs; between pixels outputs must hold with frame_tick low.
  always @(negedge clk) begin
    exp_t act, e;
    act = {vif_a.hsync, vif_a.vsync, vif_a.video_on, vif_a.rgb, vif_a.pixelX, vif_a.pixelY, vif_a.frame_tick};
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("pix_a", act, e);
      last_a = e;
    end else if (m_f[0] < NF) begin
      e = last_a;
      e.ftick = 1'b0;
      check("hold_a", act, e);
    end
    act = {vif_b.hsync, vif_b.vsync, vif_b.video_on, vif_b.rgb, vif_b.pixelX, vif_b.pixelY, vif_b.frame_tick};
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("pix_b", act, e);
      last_b = e;
    end else if (m_f[1] < NF) begin
      e = last_b;
      e.ftick = 1'b0;
      check("hold_b", act, e);
    end
  end

  initial begin
    bit found;
    rst_a = 1'b1;
    rst_b = 1'b1;
    vif_a.switch = 4'b1001;
    vif_b.switch = 4'b0001;
    repeat (5) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset the bounce instance mid-frame (frame 5, line 6).
    found = 1'b0;
    for (int c = 0; c < 20000 && !found; c++) begin
      @(negedge clk);
      if (m_f[0] == 5 && m_v[0] == 6) found = 1'b1;
    end
    check_bit("midframe_wait", found, 1'b1);
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;

    found = 1'b0;
    for (int c = 0; c < 40000 && !found; c++) begin
      @(negedge clk);
      if (m_f[0] >= NF && m_f[1] >= NF) found = 1'b1;
    end
    check_bit("run_done", found, 1'b1);
    repeat (2) @(negedge clk);

    check_bit("overlap_seen_a", ovl[0] > 0, 1'b1);
    check_bit("overlap_seen_b", ovl[1] > 0, 1'b1);
    check_bit("queues_drained", (q_a.size() == 0) && (q_b.size() == 0), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sprite_compositor.md
# vga_sprite_compositor

Parametrised next-generation VGA display core: generates the pixel-clock enable, horizontal/vertical timing, and a composited RGB stream of up to N independently controlled square sprites over a solid background. Sprite positions update once per frame from per-sprite 2-bit controllers, with bounce or wrap boundary mode. It replaces the fixed single-piece path (clock divider + synchronizer + one moving piece) at the top of the display design and drives the VGA pins directly.

## Interface
Parameters:
- CLK_DIV, 2, system clocks per pixel (2: 50 MHz → 25 MHz); must be ≥1
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal region lengths in pixels
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical region lengths in lines
- N_SPRITES, 2, number of sprites (1–8)
- SPRITE_SIZE, 16, sprite edge length in pixels
- STEP, 2, pixels moved per frame per enabled axis
- WRAP, 0, 0 = bounce at edges, 1 = wrap around
- BG_COLOR, 3'b110, background colour
- SPRITE_COLORS, {3'b010, 3'b001}, packed 3-bit colours; sprite i uses bits [3i+2:3i]

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- switch  in  2*N_SPRITES  per-sprite controller; bits [2i+1:2i] = {vert_en, horiz_en} for sprite i
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while the output pixel lies in the active region
- rgb  out  3  composited pixel colour; 0 outside the active region
- pixelX  out  10  column of the pixel currently on rgb
- pixelY  out  10  line of the pixel currently on rgb
- frame_tick  out  1  one-clk pulse when sprite positions update

## Operation
- Reset, synchronous and active-high, takes effect on the next clk edge. It clears the divider and counters, sets hsync=vsync=1, sets video_on=0, rgb=0, pixelX=pixelY=0, frame_tick=0, x_i=2·i·SPRITE_SIZE, y_i=0, and all direction bits to +.
- Divider: pix_en pulses for one clk every CLK_DIV clks. The first pulse comes CLK_DIV clks after reset is released. With CLK_DIV=1, pix_en is constantly high.
- Counters (advance on pix_en only):
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = sum of the H regions, and wraps to 0.
  - v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL.
- Sync: hsync is low when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule with the V parameters.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Hit test: sprite i hits when x_i ≤ h_cnt < x_i+SPRITE_SIZE and y_i ≤ v_cnt < y_i+SPRITE_SIZE.
- Colour priority: the lowest-index hit wins. With no hit, the colour is BG_COLOR. Outside the active region, rgb=0.
- Frame update:
  - Occurs on the pix_en where h_cnt=0 and v_cnt=V_ACTIVE, i.e. the first blanking line.
  - frame_tick pulses for that clk.
  - Each sprite axis whose enable bit is set moves STEP in its direction bit. Axes whose bit is clear hold their position and direction.
- Axis limits: MAX_X = H_ACTIVE−SPRITE_SIZE and MAX_Y = V_ACTIVE−SPRITE_SIZE. Position arithmetic uses 11 bits, so no overflow is possible.
- Bounce (WRAP=0):
  - If pos+STEP > MAX, pos=MAX and the direction flips to −.
  - If moving − and pos < STEP, pos=0 and the direction flips to +.
  - Landing exactly on a limit does not flip the direction; the flip happens on the next update.
- Wrap (WRAP=1): the direction is always +. If pos+STEP > MAX, pos = pos+STEP−(MAX+1); otherwise pos += STEP.
- Sampling: switch is sampled only at the update instant. Changes between updates have no effect.
- Sprites and background: sprites may overlap one another. Overlap is resolved purely by priority.

## Timing
- Output latency: hsync, vsync, video_on, rgb, pixelX and pixelY are all registered together, one clk after the pix_en that advanced the counters. All outputs are mutually aligned.
- Output hold: outputs change only in the clk after a pix_en, and hold for CLK_DIV clks.
- Update visibility: new sprite positions take effect from the same update instant. They are first visible on line 0 of the next frame, so there is no tearing.
- Reset mid-frame: the frame restarts at h_cnt=v_cnt=0. Positions return to their reset values, and no frame_tick is emitted.
- Frame timing (defaults): one line = 800 pixels = 1600 clks. One frame = 525 lines = 840 000 clks.

## Test plan
- Reset and outputs:
  - Hold reset 5 clks, then release.
  - During reset: hsync=vsync=1 and rgb=0.
  - First pix_en 2 clks after release.
  - pixelX=0, pixelY=0, video_on=1 and rgb=3'b001 (sprite 0 covers (0,0)) one clk after that pix_en.
- Horizontal timing (defaults):
  - hsync falls at h_cnt=656, stays low for 192 clks, and has a 1600-clk period.
  - video_on is low for columns 640–799.
- Vertical timing and frame update:
  - vsync is low on lines 490–491 only.
  - frame_tick pulses once per 840 000 clks, at line 480, column 0.
- Bounce: switch=2'b01 for sprite 0 with x_0 preset near MAX_X=624.
  - x_0 steps 620 → 622 → 624, the direction flips on the next update, then x_0 goes 622 → 620.
  - y_0 stays 0 throughout.
- Wrap and priority:
  - WRAP=1, STEP=2, x_0=623: the next update gives x_0=0.
  - With sprites 0 and 1 overlapping, the shared pixels show 3'b001 and never 3'b010.
- Reset mid-frame: assert reset at line 200.
  - The next frame starts at pixelY=0.
  - Sprites return to x_i = 0 and 32, with y=0.
  - No frame_tick appears until line 480 of the new frame.
